// File: rtl/uart_rx_top.sv
// UART receiver: 16x oversampled deframer feeding an RX FIFO or a single holding register.
// Optional receive timeout is built when UART_RX_TIMEOUT_EN is defined; otherwise timeout_o is tied low.
module uart_rx_top #(
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en_i,
  input  logic       fifo_en_i,
  input  logic       fifo_rx_reset_i,
  input  logic       tick_i,
  input  logic       parity_en_i,
  input  logic       parity_type_i,
  input  logic       stop_bit_num_i,
  input  logic [1:0] data_bit_num_i,
  input  logic       rx_i,
  input  logic       read_data_i,
  input  logic       err_clr_i,
  output logic [7:0] data_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       fifo_rx_empty_o,
  output logic       fifo_rx_full_o,
  output logic       recv_fi_o,
  output logic       timeout_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // state      | meaning
  // IDLE       | wait for falling edge; START: mid-start check; DATA/PARITY/STOP1/STOP2: bit samples
  // BREAK_WAIT | break frame pushed, hold until the line is high again
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT} state_t;
  state_t state, state_nxt;

  logic rx_s1, rx_s2, rx_prev;
  logic [3:0] tick_cnt, tick_cnt_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic par_acc, par_acc_nxt, perr, perr_nxt, ferr, ferr_nxt;
  logic f_par_en, f_par_type, f_stop2, f_par_en_nxt, f_par_type_nxt, f_stop2_nxt;
  logic [1:0] f_bits, f_bits_nxt;
  logic done, push;
  logic [9:0] push_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
      state <= IDLE; tick_cnt <= '0; bit_cnt <= '0; shreg <= '0;
      par_acc <= 1'b0; perr <= 1'b0; ferr <= 1'b0;
      f_par_en <= 1'b0; f_par_type <= 1'b0; f_stop2 <= 1'b0; f_bits <= '0;
      recv_fi_o <= 1'b0;
    end else begin
      rx_s1 <= rx_i; rx_s2 <= rx_s1; rx_prev <= rx_s2;
      state <= state_nxt; tick_cnt <= tick_cnt_nxt; bit_cnt <= bit_cnt_nxt; shreg <= shreg_nxt;
      par_acc <= par_acc_nxt; perr <= perr_nxt; ferr <= ferr_nxt;
      f_par_en <= f_par_en_nxt; f_par_type <= f_par_type_nxt; f_stop2 <= f_stop2_nxt; f_bits <= f_bits_nxt;
      recv_fi_o <= push;
    end
  end

  always_comb begin
    state_nxt = state; tick_cnt_nxt = tick_cnt; bit_cnt_nxt = bit_cnt; shreg_nxt = shreg;
    par_acc_nxt = par_acc; perr_nxt = perr; ferr_nxt = ferr;
    f_par_en_nxt = f_par_en; f_par_type_nxt = f_par_type; f_stop2_nxt = f_stop2; f_bits_nxt = f_bits;
    done = 1'b0; push = 1'b0; push_word = '0;
    if (tick_i) tick_cnt_nxt = tick_cnt + 4'd1;
    case (state)
      IDLE: if (rx_en_i && rx_prev && !rx_s2) begin
        state_nxt = START; tick_cnt_nxt = '0;
      end
      START: if (tick_i && tick_cnt == 4'd7) begin
        if (rx_s2) state_nxt = IDLE;
        else begin
          state_nxt = DATA; tick_cnt_nxt = '0; bit_cnt_nxt = '0; shreg_nxt = '0;
          par_acc_nxt = 1'b0; perr_nxt = 1'b0; ferr_nxt = 1'b0;
          f_par_en_nxt = parity_en_i; f_par_type_nxt = parity_type_i;
          f_stop2_nxt = stop_bit_num_i; f_bits_nxt = data_bit_num_i;
        end
      end
      DATA: if (tick_i && tick_cnt == 4'd15) begin
        shreg_nxt[bit_cnt] = rx_s2;
        par_acc_nxt = par_acc ^ rx_s2;
        // last data bit index is 4 + data_bit_num
        if (bit_cnt == {1'b1, f_bits}) state_nxt = f_par_en ? PARITY : STOP1;
        else bit_cnt_nxt = bit_cnt + 3'd1;
      end
      PARITY: if (tick_i && tick_cnt == 4'd15) begin
        perr_nxt = par_acc ^ rx_s2 ^ f_par_type;
        state_nxt = STOP1;
      end
      STOP1: if (tick_i && tick_cnt == 4'd15) begin
        ferr_nxt = ferr | !rx_s2;
        if (f_stop2) state_nxt = STOP2;
        else done = 1'b1;
      end
      STOP2: if (tick_i && tick_cnt == 4'd15) begin
        ferr_nxt = ferr | !rx_s2;
        done = 1'b1;
      end
      BREAK_WAIT: if (rx_s2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (done) begin
      push = 1'b1;
      push_word = {ferr_nxt, perr, shreg};
      state_nxt = (ferr_nxt && shreg == 8'd0) ? BREAK_WAIT : IDLE;
    end
    if (!rx_en_i) begin
      state_nxt = IDLE; push = 1'b0;
    end
  end

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, cap;
  logic empty, full, pop, wr, overflow;

  assign cap      = fifo_en_i ? (AW+1)'(FIFO_DEPTH) : (AW+1)'(1);
  assign empty    = (count == '0);
  assign full     = (count >= cap);
  assign pop      = read_data_i && !empty && !fifo_rx_reset_i;
  assign wr       = push && (!full || pop) && !fifo_rx_reset_i;
  assign overflow = push && full && !pop && !fifo_rx_reset_i;

  always_ff @(posedge clk) begin
    if (reset || fifo_rx_reset_i) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) overrun_o <= 1'b0;
    else if (overflow) overrun_o <= 1'b1;
    else if (err_clr_i) overrun_o <= 1'b0;
  end

  assign {frame_err_o, parity_err_o, data_o} = empty ? 10'd0 : mem[rd_ptr];
  assign fifo_rx_empty_o = empty;
  assign fifo_rx_full_o  = full;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] idle_cnt;
  logic timeout_q;

  // down-counter reloads on any buffer activity and fires at terminal count
  always_ff @(posedge clk) begin
    if (reset || wr || pop || fifo_rx_reset_i) begin
      idle_cnt <= TW'(TIMEOUT_TICKS); timeout_q <= 1'b0;
    end else if (tick_i && !empty && state == IDLE && !timeout_q) begin
      if (idle_cnt == TW'(1)) timeout_q <= 1'b1;
      idle_cnt <= idle_cnt - TW'(1);
    end
  end
  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_TICKS > 0);
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_top.sv
// Randomized scoreboard bench for uart_rx_top: frames are built from a reference model of the
// character format, expected entries are queued, and a monitor pops and compares buffered characters.
module tb_uart_rx_top;
  localparam int TDIV = 4;
  localparam int BIT  = 16 * TDIV;

  logic clk = 1'b0, reset = 1'b1, rx_en_i = 1'b0, fifo_en_i = 1'b1, fifo_rx_reset_i = 1'b0;
  logic tick_i = 1'b0, parity_en_i = 1'b0, parity_type_i = 1'b0, stop_bit_num_i = 1'b0;
  logic [1:0] data_bit_num_i = 2'd3;
  logic rx_i = 1'b1, read_data_i = 1'b0, err_clr_i = 1'b0;
  logic [7:0] data_o;
  logic parity_err_o, frame_err_o, overrun_o, fifo_rx_empty_o, fifo_rx_full_o, recv_fi_o, timeout_o;

  uart_rx_top #(.FIFO_DEPTH(16), .TIMEOUT_TICKS(640)) dut (
    .clk(clk), .reset(reset), .rx_en_i(rx_en_i), .fifo_en_i(fifo_en_i),
    .fifo_rx_reset_i(fifo_rx_reset_i), .tick_i(tick_i), .parity_en_i(parity_en_i),
    .parity_type_i(parity_type_i), .stop_bit_num_i(stop_bit_num_i), .data_bit_num_i(data_bit_num_i),
    .rx_i(rx_i), .read_data_i(read_data_i), .err_clr_i(err_clr_i), .data_o(data_o),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
    .fifo_rx_empty_o(fifo_rx_empty_o), .fifo_rx_full_o(fifo_rx_full_o), .recv_fi_o(recv_fi_o),
    .timeout_o(timeout_o));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int recv_cnt = 0, pops_req = 0, pops_done = 0;
  bit auto_read = 1'b0;
  logic [9:0] exp_q[$];

  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      tick_i = (c == 0);
      c = (c + 1) % TDIV;
    end
  end

  initial forever begin
    @(negedge clk);
    if (recv_fi_o) recv_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: services manual pop requests, otherwise drains and scores buffered characters.
  initial forever begin
    @(negedge clk);
    if (pops_done != pops_req) begin
      read_data_i = 1'b1; @(negedge clk); read_data_i = 1'b0;
      pops_done++;
    end else if (auto_read && !fifo_rx_empty_o) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_entry: got 0x%0h expected none", {frame_err_o, parity_err_o, data_o});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("entry", {22'd0, frame_err_o, parity_err_o, data_o}, {22'd0, e});
      end
      read_data_i = 1'b1; @(negedge clk); read_data_i = 1'b0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_manual();
    int k = 0;
    pops_req++;
    while (pops_done != pops_req && k < 100) begin @(negedge clk); k++; end
    check("pop_served", pops_done, pops_req);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || !fifo_rx_empty_o) && k < 3000) begin @(negedge clk); k++; end
    check("drain_queue", exp_q.size(), 0);
  endtask

  function automatic logic [9:0] model(input logic [7:0] d, input int nbits, input bit perr, input bit ferr);
    int mask;
    mask = (1 << nbits) - 1;
    return {ferr, perr, 8'(int'(d) & mask)};
  endfunction

  task automatic set_fmt(input int nbits, input bit pen, input bit ptype, input bit two);
    data_bit_num_i = 2'(nbits - 5); parity_en_i = pen; parity_type_i = ptype; stop_bit_num_i = two;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit ptype,
                            input bit two, input bit flip, input bit stop_low);
    logic par;
    par = ptype ^ flip;
    rx_i = 1'b0; wait_clk(BIT);
    for (int i = 0; i < nbits; i++) begin
      rx_i = d[i]; par = par ^ d[i]; wait_clk(BIT);
    end
    if (pen) begin rx_i = par; wait_clk(BIT); end
    rx_i = !stop_low; wait_clk(BIT);
    if (two) wait_clk(BIT);
    rx_i = 1'b1; wait_clk(BIT);
  endtask

  task automatic send_expect(input logic [7:0] d, input int nbits, input bit pen, input bit ptype,
                             input bit two, input bit flip, input bit stop_low);
    set_fmt(nbits, pen, ptype, two);
    exp_q.push_back(model(d, nbits, pen && flip, stop_low));
    send_frame(d, nbits, pen, ptype, two, flip, stop_low);
  endtask

  initial begin
    int r0, k;
    wait_clk(5);
    check("rst_data", data_o, 0);
    check("rst_perr", parity_err_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_empty", fifo_rx_empty_o, 1);
    check("rst_full", fifo_rx_full_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_recv", recv_fi_o, 0);
    check("rst_timeout", timeout_o, 0);
    reset = 1'b0; rx_en_i = 1'b1;
    wait_clk(5);

    // 8N1 0xA5, manual read
    r0 = recv_cnt;
    set_fmt(8, 0, 0, 0);
    send_frame(8'hA5, 8, 0, 0, 0, 0, 0);
    check("a5_recv", recv_cnt - r0, 1);
    check("a5_data", data_o, 8'hA5);
    check("a5_perr", parity_err_o, 0);
    check("a5_ferr", frame_err_o, 0);
    pop_manual();
    check("a5_empty", fifo_rx_empty_o, 1);

    auto_read = 1'b1;
    send_expect(8'h35, 7, 1, 0, 1, 0, 0);
    send_expect(8'h35, 7, 1, 0, 1, 1, 0);
    drain();

    send_expect(8'h1F, 5, 0, 0, 0, 0, 1);
    drain();
    r0 = recv_cnt;
    rx_i = 1'b0; wait_clk(BIT / 2 - 8); rx_i = 1'b1; wait_clk(3 * BIT);
    check("glitch_no_push", recv_cnt - r0, 0);
    check("glitch_empty", fifo_rx_empty_o, 1);

    // break: line low for two frame times
    set_fmt(8, 0, 0, 0);
    r0 = recv_cnt;
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    rx_i = 1'b0; wait_clk(20 * BIT);
    check("break_one_push", recv_cnt - r0, 1);
    rx_i = 1'b1; wait_clk(BIT);
    send_expect(8'h55, 8, 0, 0, 0, 0, 0);
    drain();
    check("break_then_55", recv_cnt - r0, 2);

    for (int i = 0; i < 12; i++) begin
      int nb; bit pen, pt, two, fl, sl;
      nb = $urandom_range(5, 8); pen = 1'($urandom_range(0, 1)); pt = 1'($urandom_range(0, 1));
      two = 1'($urandom_range(0, 1)); fl = pen & 1'($urandom_range(0, 1));
      sl = ($urandom_range(0, 3) == 0);
      send_expect(8'($urandom), nb, pen, pt, two, fl, sl);
    end
    drain();

    // abort by rx_en low mid-frame
    r0 = recv_cnt;
    rx_i = 1'b0; wait_clk(3 * BIT);
    rx_en_i = 1'b0; wait_clk(10); rx_i = 1'b1; wait_clk(2); rx_en_i = 1'b1;
    wait_clk(12 * BIT);
    check("abort_no_push", recv_cnt - r0, 0);
    check("abort_empty", fifo_rx_empty_o, 1);

    // FIFO fill and overrun
    auto_read = 1'b0;
    set_fmt(8, 0, 0, 0);
    r0 = recv_cnt;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 8, 0, 0, 0, 0, 0);
      if (i < 16) exp_q.push_back({2'b00, 8'(i)});
      if (i == 15) begin
        check("fifo_full16", fifo_rx_full_o, 1);
        check("fifo_no_ovr16", overrun_o, 0);
      end
    end
    check("fifo_recv17", recv_cnt - r0, 17);
    check("fifo_full17", fifo_rx_full_o, 1);
    check("fifo_ovr17", overrun_o, 1);
    auto_read = 1'b1;
    drain();
    check("fifo_drained_empty", fifo_rx_empty_o, 1);
    check("fifo_ovr_sticky", overrun_o, 1);
    err_clr_i = 1'b1; wait_clk(1); err_clr_i = 1'b0;
    check("err_clr", overrun_o, 0);

    // holding register mode
    auto_read = 1'b0; fifo_en_i = 1'b0;
    send_frame(8'h3A, 8, 0, 0, 0, 0, 0);
    check("hold_full", fifo_rx_full_o, 1);
    check("hold_overrun0", overrun_o, 0);
    send_frame(8'hC4, 8, 0, 0, 0, 0, 0);
    check("hold_overrun", overrun_o, 1);
    check("hold_data", data_o, 8'h3A);
    pop_manual();
    check("hold_empty", fifo_rx_empty_o, 1);
    err_clr_i = 1'b1; wait_clk(1); err_clr_i = 1'b0;
    fifo_en_i = 1'b1;

    // flush
    send_frame(8'h3C, 8, 0, 0, 0, 0, 0);
    check("flush_pre", fifo_rx_empty_o, 0);
    fifo_rx_reset_i = 1'b1; wait_clk(1); fifo_rx_reset_i = 1'b0;
    check("flush_empty", fifo_rx_empty_o, 1);
    check("flush_data", data_o, 0);

    // receive timeout
    send_frame(8'h77, 8, 0, 0, 0, 0, 0);
    check("to_initial", timeout_o, 0);
    wait_clk(590 * TDIV);
`ifdef UART_RX_TIMEOUT_EN
    check("to_early", timeout_o, 0);
    k = 0;
    while (!timeout_o && k < 80 * TDIV) begin @(negedge clk); k++; end
    check("to_set", timeout_o, 1);
`else
    k = 0;
    while (!timeout_o && k < 80 * TDIV) begin @(negedge clk); k++; end
    check("to_tied", timeout_o, 0);
`endif
    pop_manual();
    check("to_clear", timeout_o, 0);
    check("to_empty", fifo_rx_empty_o, 1);
    check("queue_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

Receive-side counterpart of the UART transmit path: oversamples the serial line on the shared 16x baud tick, deframes start/data/parity/stop bits and buffers received characters in an optional FIFO. It sits between the pad-side `rx_i` line and the APB register file. It honours the same frame-format controls as the transmitter: data bits, parity enable/type and stop bits.

## Interface
- `FIFO_DEPTH`, 16, RX FIFO entries (power of two, >= 2); each entry stores 8 data bits, a parity error flag and a framing error flag.
- `TIMEOUT_TICKS`, 640, idle-tick count for the receive timeout (40 bit times at 16x).
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `rx_en_i` in 1: receiver enable.
- `fifo_en_i` in 1: 1 = FIFO mode, 0 = single holding register.
- `fifo_rx_reset_i` in 1: synchronous flush of FIFO/holding register.
- `tick_i` in 1: 16x baud enable pulse, one `clk` wide.
- `parity_en_i` in 1: parity bit present.
- `parity_type_i` in 1: 0 = even, 1 = odd.
- `stop_bit_num_i` in 1: 0 = one stop bit, 1 = two.
- `data_bit_num_i` in 2: 00/01/10/11 = 5/6/7/8 data bits.
- `rx_i` in 1: asynchronous serial input, idle high.
- `read_data_i` in 1: one-cycle pop strobe.
- `err_clr_i` in 1: clears the sticky overrun flag.
- `data_o` out 8: head character, right-aligned, unused MSBs 0.
- `parity_err_o` out 1: parity error flag of the head entry.
- `frame_err_o` out 1: framing error flag of the head entry.
- `overrun_o` out 1: sticky overrun flag.
- `fifo_rx_empty_o` out 1: no character available.
- `fifo_rx_full_o` out 1: no space available.
- `recv_fi_o` out 1: one-cycle pulse when a frame completes.
- `timeout_o` out 1: receive timeout (macro-dependent).

## Operation
- `rx_i` passes through a 2-flop synchronizer, initialised to 1. All sampling uses the synchronized signal.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT. A 4-bit tick counter and a 3-bit bit counter advance only on `tick_i`.
- IDLE → START on a synchronized 1→0 transition with `rx_en_i` high. The counter clears.
- START: on the 8th tick (mid-bit) the line is sampled.
  - Line high: false start, return to IDLE.
  - Line low: go to DATA with the counter cleared.
- DATA: sample every 16 ticks, LSB first, for 5–8 bits. Then go to PARITY if `parity_en_i`, else STOP1.
- PARITY: computed parity ^ received bit ^ `parity_type_i`; a nonzero result sets the parity error.
- STOP1: sample. A low sample is a framing error. Go to STOP2 if `stop_bit_num_i`, else complete. STOP2 checks identically.
- Completion occurs at the mid-sample of the last stop bit:
  - push {frame_err, parity_err, data};
  - pulse `recv_fi_o`;
  - return to IDLE, so a next start bit half a bit later is caught.
- Break: data all 0 and framing error. The frame is pushed, then the FSM enters BREAK_WAIT and holds there until the line is sampled high before re-arming IDLE.
- Frame-format inputs are sampled at the START→DATA transition and held for the frame.
- `rx_en_i` low aborts any frame immediately to IDLE; the partial character is discarded and nothing is pushed.
- FIFO mode:
  - pop = `read_data_i` & !empty;
  - push when not full;
  - push while full drops the character and sets `overrun_o`;
  - simultaneous pop and push when full is legal (pop first, no overrun);
  - pop when empty is ignored.
- Holding mode:
  - one entry;
  - empty = !valid, full = valid;
  - a new frame while valid is dropped and sets `overrun_o`;
  - `read_data_i` clears valid.
- `fifo_rx_reset_i` empties the buffer. It does not affect the FSM or `overrun_o`.
- `err_clr_i` clears `overrun_o`. A same-cycle new overrun wins.

## Timing
- Reset values:
  - `data_o`, `parity_err_o`, `frame_err_o` = 0;
  - `fifo_rx_empty_o` = 1;
  - `fifo_rx_full_o`, `overrun_o`, `recv_fi_o`, `timeout_o` = 0;
  - FSM = IDLE, FIFO pointers 0.
- Reset mid-frame returns everything to reset values on the next edge.
- Latency from `rx_i` to synchronized value: 2 `clk` cycles.
- Push and `recv_fi_o` occur in the `clk` cycle after the `tick_i` that samples the final stop bit. `fifo_rx_empty_o` falls on the same edge.
- `data_o` and the head error flags are registered-head outputs, valid whenever empty is 0. After a pop edge they show the next entry.
- Flags (empty, full, overrun) update on the same edge as the push or pop that causes them.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - an idle counter counts `tick_i` while the buffer is non-empty and the FSM is in IDLE;
  - the counter clears on any push, pop or flush;
  - at `TIMEOUT_TICKS` it sets `timeout_o`, which stays high until the next pop, push or flush.
- Not defined: no counter logic, and `timeout_o` is tied 0.

## Test plan
- 8N1, FIFO mode, send 0xA5 → `recv_fi_o` pulses once, `data_o` = 0xA5, both error flags 0; one `read_data_i` → `fifo_rx_empty_o` = 1.
- 7E2, send 0x35 with correct parity, then 0x35 with the parity bit flipped → entries 0x35/perr 0 and 0x35/perr 1.
- 5-bit, stop sampled low → `frame_err_o` = 1, `data_o` = 0x1F for an input of 0x1F. Then a 3-bit-time line glitch low of half a bit → false start, no push.
- Break: line low for 2 frame times → one entry 0x00 with ferr = 1. No further push until the line returns high; the next frame, 0x55, is received correctly.
- FIFO: send 17 characters with no reads → full after 16, 17th dropped, `overrun_o` = 1; read all 16 → values 0..15 in order; `err_clr_i` → `overrun_o` = 0.
- With `UART_RX_TIMEOUT_EN`: one character left unread for 640 ticks → `timeout_o` = 1; a pop → `timeout_o` = 0. Without the macro: `timeout_o` stays 0.
